// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
// REG_RANGE is the common register bit range used for PCs and instruction words.
`ifndef REG_RANGE
`define REG_RANGE 31:0
`endif

package fetch_pkg;

  typedef struct packed {
    logic [`REG_RANGE] pc;
    logic [`REG_RANGE] inst;
  } fetch_entry_t;

  localparam logic [`REG_RANGE] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam logic [`REG_RANGE] PC_INCR          = 32'd4;

endpackage

// File: rtl/fetch_queue.sv
// Synchronous FIFO of fetch entries with flush.
// The head output is zeroed while the queue is empty.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         push_i,
  input  fetch_entry_t entry_i,
  input  logic         pop_i,
  input  logic         flush_i,
  output fetch_entry_t head_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  fetch_entry_t     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] cnt_q;
  logic             do_push, do_pop;

  assign full_o  = (cnt_q == FULL_CNT);
  assign empty_o = (cnt_q == '0);
  // Flush dominates both operations; the guards keep the count inside [0, DEPTH].
  assign do_pop  = pop_i && !empty_o && !flush_i;
  assign do_push = push_i && (!full_o || do_pop) && !flush_i;
  assign head_o  = empty_o ? '0 : mem_q[rd_ptr_q];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (do_push && !do_pop)      cnt_q <= cnt_q + 1'b1;
      else if (do_pop && !do_push) cnt_q <= cnt_q - 1'b1;
    end
  end

  // Storage is data only; validity is tracked by the pointers and count.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= entry_i;
  end

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch: PC sequencing with redirect, feeding a small fetch queue.
// Define FETCH_PERF_EN to add fetch_count / stall_count performance outputs.
module instruction_fetch
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] mem_pc,
  input  logic [31:0] mem_inst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_inst,
`ifdef FETCH_PERF_EN
  output logic [31:0] fetch_count,
  output logic [31:0] stall_count,
`endif
  output logic [31:0] out_pc
);

  logic [31:0]  pc_q, pc_d;
  logic         push, pop, full, empty;
  fetch_entry_t wr_entry, head;

  assign pop       = out_valid && out_ready;
  assign push      = !redirect_valid && (!full || pop);
  assign wr_entry  = '{pc: pc_q, inst: mem_inst};
  assign mem_pc    = pc_q;
  assign out_valid = !empty;
  assign out_pc    = head.pc;
  assign out_inst  = head.inst;

  always_comb begin
    pc_d = pc_q;
    if (redirect_valid) pc_d = {redirect_pc[31:2], 2'b00};
    else if (push)      pc_d = pc_q + PC_INCR;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) pc_q <= RESET_PC;
    else        pc_q <= pc_d;
  end

  fetch_queue #(.DEPTH(DEPTH)) u_queue (
    .clk_i   (clk),
    .rst_ni  (reset),
    .push_i  (push),
    .entry_i (wr_entry),
    .pop_i   (pop),
    .flush_i (redirect_valid),
    .head_o  (head),
    .full_o  (full),
    .empty_o (empty)
  );

`ifdef FETCH_PERF_EN
  logic [31:0] fetch_count_q, stall_count_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_count_q <= '0;
      stall_count_q <= '0;
    end else begin
      if (push) fetch_count_q <= fetch_count_q + 1'b1;
      if (full && !pop && !redirect_valid) stall_count_q <= stall_count_q + 1'b1;
    end
  end

  assign fetch_count = fetch_count_q;
  assign stall_count = stall_count_q;
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed testbench for instruction_fetch with a combinational memory model
// returning inst = addr ^ 32'hA5A5_A5A5.
module tb_instruction_fetch;

  localparam logic [31:0] KEY = 32'hA5A5_A5A5;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] mem_pc, mem_inst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid, out_ready;
  logic [31:0] out_inst, out_pc;
`ifdef FETCH_PERF_EN
  logic [31:0] fetch_count, stall_count;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  assign mem_inst = mem_pc ^ KEY;

  instruction_fetch #(.RESET_PC(32'h0000_0000), .DEPTH(2)) dut (
    .clk            (clk),
    .reset          (reset),
    .mem_pc         (mem_pc),
    .mem_inst       (mem_inst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_inst       (out_inst),
`ifdef FETCH_PERF_EN
    .fetch_count    (fetch_count),
    .stall_count    (stall_count),
`endif
    .out_pc         (out_pc)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk_head(input string tag, input logic [31:0] pc);
    chk({tag, "_vld"}, {31'b0, out_valid}, 32'd1);
    chk({tag, "_pc"}, out_pc, pc);
    chk({tag, "_inst"}, out_inst, pc ^ KEY);
  endtask

  task automatic do_reset();
    reset          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    out_ready      = 1'b0;
    @(negedge clk);
    chk("rst_vld", {31'b0, out_valid}, 32'd0);
    chk("rst_pc", out_pc, 32'd0);
    chk("rst_inst", out_inst, 32'd0);
    chk("rst_mempc", mem_pc, 32'd0);
    reset = 1'b1;
  endtask

  initial begin
    // Streaming with decode always ready
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk_head("stream", 32'(4 * i));
      chk("stream_mempc", mem_pc, 32'(4 * (i + 1)));
    end

    // Backpressure: fill, hold, then drain without loss
    do_reset();
    tick();
    chk("bp_mempc1", mem_pc, 32'h4);
    chk_head("bp_h1", 32'h0);
    tick();
    chk("bp_mempc2", mem_pc, 32'h8);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bp_hold_mempc", mem_pc, 32'h8);
      chk_head("bp_hold", 32'h0);
    end
    out_ready = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      tick();
      chk_head("bp_drain", 32'(4 * i));
    end

    // Redirect to unaligned target while full
    do_reset();
    tick();
    tick();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0103;
    tick();
    chk("rd_vld", {31'b0, out_valid}, 32'd0);
    chk("rd_pc", out_pc, 32'd0);
    chk("rd_mempc", mem_pc, 32'h100);
    redirect_valid = 1'b0;
    out_ready      = 1'b1;
    tick();
    chk_head("rd_t0", 32'h100);
    chk("rd_mempc2", mem_pc, 32'h104);
    tick();
    chk_head("rd_t1", 32'h104);

    // Redirect coinciding with a pop of a full queue
    do_reset();
    tick();
    tick();
    out_ready      = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0040;
    tick();
    chk("rp_vld", {31'b0, out_valid}, 32'd0);
    chk("rp_mempc", mem_pc, 32'h40);
    redirect_valid = 1'b0;
    tick();
    chk_head("rp_t0", 32'h40);
    tick();
    chk_head("rp_t1", 32'h44);

    // PC wrap at the top of the address space
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFF8;
    tick();
    chk("wr_vld", {31'b0, out_valid}, 32'd0);
    redirect_valid = 1'b0;
    tick();
    chk_head("wr_t0", 32'hFFFF_FFF8);
    tick();
    chk_head("wr_t1", 32'hFFFF_FFFC);
    chk("wr_mempc", mem_pc, 32'h0);
    tick();
    chk_head("wr_t2", 32'h0);
    chk("wr_mempc2", mem_pc, 32'h4);

    // Asynchronous reset mid-stream with two queued entries
    do_reset();
    tick();
    tick();
`ifdef FETCH_PERF_EN
    chk("perf_fetch", fetch_count, 32'd2);
    chk("perf_stall0", stall_count, 32'd0);
`endif
    tick();
`ifdef FETCH_PERF_EN
    chk("perf_stall1", stall_count, 32'd1);
`endif
    chk_head("ar_pre", 32'h0);
    #2 reset = 1'b0;
    #1;
    chk("ar_vld", {31'b0, out_valid}, 32'd0);
    chk("ar_pc", out_pc, 32'd0);
    chk("ar_inst", out_inst, 32'd0);
    chk("ar_mempc", mem_pc, 32'd0);
`ifdef FETCH_PERF_EN
    chk("ar_fetch", fetch_count, 32'd0);
    chk("ar_stall", stall_count, 32'd0);
`endif
    @(negedge clk);
    reset     = 1'b1;
    out_ready = 1'b1;
    tick();
    chk_head("ar_post", 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
